// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : control_unit                                                    |
// | Purpose  : Hardwired Moore sequencer for the Mini SRC CPU. Fetches an      |
// |            instruction (T0-T2), decodes IR[31:27] and steps through the    |
// |            execute states T3-T7, driving every datapath control strobe.    |
// | Ports    : clock/clear       - clock, asynchronous active-high reset        |
// |            mem_ready         - memory handshake (CTRL_MEM_WAIT_EN only)     |
// |            IR, CONFF, Stop   - instruction, branch condition, halt request  |
// |            Gra..CONin        - register select, bus, load and I/O strobes   |
// |            alu_op            - ALU operation select                         |
// |            Run               - high while the CPU is executing              |
// | Options  : `define CTRL_MEM_WAIT_EN adds mem_ready; states that assert     |
// |            Read or Write then hold until mem_ready is sampled high.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module control_unit #(
   parameter logic [3:0] ALU_ADD = 4'h4
) (
   input  logic        clock,
   input  logic        clear,
`ifdef CTRL_MEM_WAIT_EN
   input  logic        mem_ready,
`endif
   input  logic [31:0] IR,
   input  logic        CONFF,
   input  logic        Stop,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Csignout,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        MD_read,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Zhighin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        Read,
   output logic        Write,
   output logic        InPortout,
   output logic        Out_Portin,
   output logic        CONin,
   output logic [3:0]  alu_op,
   output logic        Run
);

   // Opcodes (IR[31:27])
   localparam logic [4:0] c_OP_LD   = 5'd0;
   localparam logic [4:0] c_OP_LDI  = 5'd1;
   localparam logic [4:0] c_OP_ST   = 5'd2;
   localparam logic [4:0] c_OP_ADD  = 5'd3;
   localparam logic [4:0] c_OP_SUB  = 5'd4;
   localparam logic [4:0] c_OP_AND  = 5'd5;
   localparam logic [4:0] c_OP_OR   = 5'd6;
   localparam logic [4:0] c_OP_SHR  = 5'd7;
   localparam logic [4:0] c_OP_SHL  = 5'd8;
   localparam logic [4:0] c_OP_ROR  = 5'd9;
   localparam logic [4:0] c_OP_ROL  = 5'd10;
   localparam logic [4:0] c_OP_ADDI = 5'd11;
   localparam logic [4:0] c_OP_ANDI = 5'd12;
   localparam logic [4:0] c_OP_ORI  = 5'd13;
   localparam logic [4:0] c_OP_MUL  = 5'd14;
   localparam logic [4:0] c_OP_DIV  = 5'd15;
   localparam logic [4:0] c_OP_NEG  = 5'd16;
   localparam logic [4:0] c_OP_NOT  = 5'd17;
   localparam logic [4:0] c_OP_BR   = 5'd18;
   localparam logic [4:0] c_OP_JR   = 5'd19;
   localparam logic [4:0] c_OP_IN   = 5'd21;
   localparam logic [4:0] c_OP_OUT  = 5'd22;
   localparam logic [4:0] c_OP_MFHI = 5'd23;
   localparam logic [4:0] c_OP_MFLO = 5'd24;
   localparam logic [4:0] c_OP_HALT = 5'd26;

   // ALU operation codes (add is the ALU_ADD parameter)
   localparam logic [3:0] c_ALU_AND = 4'h0;
   localparam logic [3:0] c_ALU_OR  = 4'h1;
   localparam logic [3:0] c_ALU_SUB = 4'h5;
   localparam logic [3:0] c_ALU_SHR = 4'h6;
   localparam logic [3:0] c_ALU_SHL = 4'h7;
   localparam logic [3:0] c_ALU_ROR = 4'h8;
   localparam logic [3:0] c_ALU_ROL = 4'h9;
   localparam logic [3:0] c_ALU_MUL = 4'hA;
   localparam logic [3:0] c_ALU_DIV = 4'hB;
   localparam logic [3:0] c_ALU_NEG = 4'hC;
   localparam logic [3:0] c_ALU_NOT = 4'hD;

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_T7    = 4'd8,
      S_HALT  = 4'd9
   } state_t;

   state_t     state_q;
   state_t     state_d;
   state_t     last_state;
   logic [4:0] opcode;
   logic [3:0] alu_code;
   logic       mem_ok;
   logic       mem_state;
   logic       ir_unused;

   logic is_ld, is_st, is_ldi, is_alu, is_imm, is_muldiv, is_unary;
   logic is_br, is_jr, is_in, is_out, is_mfhi, is_mflo, is_halt;

   assign opcode    = IR[31:27];
   assign ir_unused = ^IR[26:0];

   assign is_ld     = (opcode == c_OP_LD);
   assign is_st     = (opcode == c_OP_ST);
   assign is_ldi    = (opcode == c_OP_LDI);
   assign is_alu    = (opcode >= c_OP_ADD) && (opcode <= c_OP_ROL);
   assign is_imm    = (opcode >= c_OP_ADDI) && (opcode <= c_OP_ORI);
   assign is_muldiv = (opcode == c_OP_MUL) || (opcode == c_OP_DIV);
   assign is_unary  = (opcode == c_OP_NEG) || (opcode == c_OP_NOT);
   assign is_br     = (opcode == c_OP_BR);
   assign is_jr     = (opcode == c_OP_JR);
   assign is_in     = (opcode == c_OP_IN);
   assign is_out    = (opcode == c_OP_OUT);
   assign is_mfhi   = (opcode == c_OP_MFHI);
   assign is_mflo   = (opcode == c_OP_MFLO);
   assign is_halt   = (opcode == c_OP_HALT);

`ifdef CTRL_MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   // States that strobe Read or Write; these wait on the memory handshake.
   assign mem_state = (state_q == S_T1) ||
                      ((state_q == S_T6) && is_ld) ||
                      ((state_q == S_T7) && is_st);

   always_comb begin
      case (opcode)
         c_OP_SUB:  alu_code = c_ALU_SUB;
         c_OP_AND:  alu_code = c_ALU_AND;
         c_OP_OR:   alu_code = c_ALU_OR;
         c_OP_SHR:  alu_code = c_ALU_SHR;
         c_OP_SHL:  alu_code = c_ALU_SHL;
         c_OP_ROR:  alu_code = c_ALU_ROR;
         c_OP_ROL:  alu_code = c_ALU_ROL;
         c_OP_ANDI: alu_code = c_ALU_AND;
         c_OP_ORI:  alu_code = c_ALU_OR;
         c_OP_MUL:  alu_code = c_ALU_MUL;
         c_OP_DIV:  alu_code = c_ALU_DIV;
         c_OP_NEG:  alu_code = c_ALU_NEG;
         c_OP_NOT:  alu_code = c_ALU_NOT;
         default:   alu_code = ALU_ADD;    // add, addi, ldi and everything else
      endcase
   end

   // Final execute state of the current instruction; undefined opcodes end at T3.
   always_comb begin
      if (is_ld || is_st)
         last_state = S_T7;
      else if (is_br || is_muldiv)
         last_state = S_T6;
      else if (is_alu || is_imm || is_ldi)
         last_state = S_T5;
      else if (is_unary)
         last_state = S_T4;
      else
         last_state = S_T3;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_HALT:  state_d = S_HALT;
         default: begin
            if (mem_state && !mem_ok)
               state_d = state_q;
            else if ((state_q == S_T3) && is_halt)
               state_d = S_HALT;
            // T7 always ends an instruction, even if IR were to change under us.
            else if ((state_q == last_state) || (state_q == S_T7))
               state_d = Stop ? S_HALT : S_T0;
            else
               state_d = state_t'(state_q + 4'd1);
         end
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear)
         state_q <= S_RESET;
      else
         state_q <= state_d;
   end

   always_comb begin
      Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;
      BAout = 1'b0;  Csignout = 1'b0;  PCout = 1'b0;  PCin = 1'b0;  IncPC = 1'b0;
      MARin = 1'b0;  MDRin = 1'b0;  MDRout = 1'b0;  MD_read = 1'b0;  IRin = 1'b0;
      Yin = 1'b0;  Zlowin = 1'b0;  Zhighin = 1'b0;  Zlowout = 1'b0;  Zhighout = 1'b0;
      HIin = 1'b0;  LOin = 1'b0;  HIout = 1'b0;  LOout = 1'b0;  Read = 1'b0;
      Write = 1'b0;  InPortout = 1'b0;  Out_Portin = 1'b0;  CONin = 1'b0;
      alu_op = ALU_ADD;
      Run = (state_q != S_RESET) && (state_q != S_HALT);

      case (state_q)
         S_T0: begin
            PCout = 1'b1;  MARin = 1'b1;  IncPC = 1'b1;  Zlowin = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;  PCin = 1'b1;  Read = 1'b1;  MD_read = 1'b1;  MDRin = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;  IRin = 1'b1;
         end
         S_T3: begin
            if (is_alu || is_imm || is_ldi) begin
               Grb = 1'b1;  Rout = 1'b1;  Yin = 1'b1;  BAout = is_ldi;
            end else if (is_ld || is_st) begin
               Grb = 1'b1;  BAout = 1'b1;  Yin = 1'b1;
            end else if (is_muldiv) begin
               Gra = 1'b1;  Rout = 1'b1;  Yin = 1'b1;
            end else if (is_unary) begin
               Grb = 1'b1;  Rout = 1'b1;  alu_op = alu_code;  Zlowin = 1'b1;
            end else if (is_br) begin
               Gra = 1'b1;  Rout = 1'b1;  CONin = 1'b1;
            end else if (is_jr) begin
               Gra = 1'b1;  Rout = 1'b1;  PCin = 1'b1;
            end else if (is_in) begin
               InPortout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
            end else if (is_out) begin
               Gra = 1'b1;  Rout = 1'b1;  Out_Portin = 1'b1;
            end else if (is_mfhi) begin
               HIout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
            end else if (is_mflo) begin
               LOout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
            end
         end
         S_T4: begin
            if (is_alu) begin
               Grc = 1'b1;  Rout = 1'b1;  alu_op = alu_code;  Zlowin = 1'b1;
            end else if (is_imm || is_ldi) begin
               Csignout = 1'b1;  alu_op = alu_code;  Zlowin = 1'b1;
            end else if (is_ld || is_st) begin
               Csignout = 1'b1;  Zlowin = 1'b1;
            end else if (is_muldiv) begin
               Grb = 1'b1;  Rout = 1'b1;  alu_op = alu_code;  Zlowin = 1'b1;  Zhighin = 1'b1;
            end else if (is_unary) begin
               Zlowout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
            end else if (is_br) begin
               PCout = 1'b1;  Yin = 1'b1;
            end
         end
         S_T5: begin
            if (is_alu || is_imm || is_ldi) begin
               Zlowout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
            end else if (is_ld || is_st) begin
               Zlowout = 1'b1;  MARin = 1'b1;
            end else if (is_muldiv) begin
               Zlowout = 1'b1;  LOin = 1'b1;
            end else if (is_br) begin
               Csignout = 1'b1;  Zlowin = 1'b1;
            end
         end
         S_T6: begin
            if (is_ld) begin
               Read = 1'b1;  MD_read = 1'b1;  MDRin = 1'b1;
            end else if (is_st) begin
               Gra = 1'b1;  Rout = 1'b1;  MDRin = 1'b1;
            end else if (is_muldiv) begin
               Zhighout = 1'b1;  HIin = 1'b1;
            end else if (is_br) begin
               // Branch target is written only when the condition held in T3.
               Zlowout = 1'b1;  PCin = CONFF;
            end
         end
         S_T7: begin
            if (is_ld) begin
               MDRout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
            end else if (is_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_control_unit                                                 |
// | Purpose  : Self-checking bench for control_unit. Expected per-cycle strobe |
// |            vectors are queued as each instruction is issued and compared   |
// |            cycle by cycle against the packed DUT outputs.                  |
// | Options  : honours `define CTRL_MEM_WAIT_EN (mem_ready hold in ld T6).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_control_unit;

   // Strobe bit positions in the packed observation vector
   localparam logic [29:0] M_GRA     = 30'd1 << 0;
   localparam logic [29:0] M_GRB     = 30'd1 << 1;
   localparam logic [29:0] M_GRC     = 30'd1 << 2;
   localparam logic [29:0] M_RIN     = 30'd1 << 3;
   localparam logic [29:0] M_ROUT    = 30'd1 << 4;
   localparam logic [29:0] M_BAOUT   = 30'd1 << 5;
   localparam logic [29:0] M_CSIGN   = 30'd1 << 6;
   localparam logic [29:0] M_PCOUT   = 30'd1 << 7;
   localparam logic [29:0] M_PCIN    = 30'd1 << 8;
   localparam logic [29:0] M_INCPC   = 30'd1 << 9;
   localparam logic [29:0] M_MARIN   = 30'd1 << 10;
   localparam logic [29:0] M_MDRIN   = 30'd1 << 11;
   localparam logic [29:0] M_MDROUT  = 30'd1 << 12;
   localparam logic [29:0] M_MDREAD  = 30'd1 << 13;
   localparam logic [29:0] M_IRIN    = 30'd1 << 14;
   localparam logic [29:0] M_YIN     = 30'd1 << 15;
   localparam logic [29:0] M_ZLOWIN  = 30'd1 << 16;
   localparam logic [29:0] M_ZHIGHIN = 30'd1 << 17;
   localparam logic [29:0] M_ZLOWOUT = 30'd1 << 18;
   localparam logic [29:0] M_ZHIOUT  = 30'd1 << 19;
   localparam logic [29:0] M_HIIN    = 30'd1 << 20;
   localparam logic [29:0] M_LOIN    = 30'd1 << 21;
   localparam logic [29:0] M_HIOUT   = 30'd1 << 22;
   localparam logic [29:0] M_LOOUT   = 30'd1 << 23;
   localparam logic [29:0] M_READ    = 30'd1 << 24;
   localparam logic [29:0] M_WRITE   = 30'd1 << 25;
   localparam logic [29:0] M_INPORT  = 30'd1 << 26;
   localparam logic [29:0] M_OUTPORT = 30'd1 << 27;
   localparam logic [29:0] M_CONIN   = 30'd1 << 28;
   localparam logic [29:0] M_RUN     = 30'd1 << 29;

   localparam logic [31:0] c_IR_NOP  = 32'hC8000000;
   localparam logic [31:0] c_IR_ADD  = 32'h18918000;
   localparam logic [31:0] c_IR_BR   = 32'h90000014;
   localparam logic [31:0] c_IR_LD   = 32'h00000000;
   localparam logic [31:0] c_IR_LDI  = 32'h08000000;
   localparam logic [31:0] c_IR_ST   = 32'h10000000;
   localparam logic [31:0] c_IR_MUL  = 32'h70000000;
   localparam logic [31:0] c_IR_NEG  = 32'h80000000;
   localparam logic [31:0] c_IR_UND  = 32'hA0000000;   // opcode 20
   localparam logic [31:0] c_IR_HALT = 32'hD0000000;

   typedef struct packed {
      logic [29:0] sig;
      logic [3:0]  alu;
      logic [63:0] tag;
   } exp_t;

   logic        clock;
   logic        clear;
   logic [31:0] IR;
   logic        CONFF;
   logic        Stop;
`ifdef CTRL_MEM_WAIT_EN
   logic        mem_ready;
`endif
   logic Gra, Grb, Grc, Rin, Rout, BAout, Csignout, PCout, PCin, IncPC;
   logic MARin, MDRin, MDRout, MD_read, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout;
   logic HIin, LOin, HIout, LOout, Read, Write, InPortout, Out_Portin, CONin, Run;
   logic [3:0]  alu_op;
   logic [29:0] obs;

   exp_t sb_q[$];
   int   n_checks;
   int   n_fail;

   control_unit #(.ALU_ADD(4'h4)) dut (
      .clock(clock), .clear(clear),
`ifdef CTRL_MEM_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .IR(IR), .CONFF(CONFF), .Stop(Stop),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .Csignout(Csignout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .MD_read(MD_read), .IRin(IRin), .Yin(Yin),
      .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Read(Read),
      .Write(Write), .InPortout(InPortout), .Out_Portin(Out_Portin), .CONin(CONin),
      .alu_op(alu_op), .Run(Run)
   );

   assign obs = {Run, CONin, Out_Portin, InPortout, Write, Read, LOout, HIout, LOin, HIin,
                 Zhighout, Zlowout, Zhighin, Zlowin, Yin, IRin, MD_read, MDRout, MDRin,
                 MARin, IncPC, PCin, PCout, Csignout, BAout, Rout, Rin, Grc, Grb, Gra};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [29:0] s, input logic [3:0] a, input logic [63:0] t);
      exp_t e;
      e.sig = s;
      e.alu = a;
      e.tag = t;
      sb_q.push_back(e);
   endtask

   task automatic push_fetch();
      push(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 4'h4, "FETCH_T0");
      push(M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDREAD | M_MDRIN, 4'h4, "FETCH_T1");
      push(M_RUN | M_MDROUT | M_IRIN, 4'h4, "FETCH_T2");
   endtask

   task automatic test_reset();
      exp_t e;
      clear = 1'b1;
      IR    = c_IR_NOP;
      repeat (2) @(posedge clock);
      #1;
      n_checks++;
      if (obs !== 30'd0 || alu_op !== 4'h4) begin
         n_fail++;
         $display("FAIL reset_hold: got sig=%h alu=%h, expected sig=%h alu=%h", obs, alu_op, 30'd0, 4'h4);
      end
      clear = 1'b0;
      tick();
      push_fetch();
      push(M_RUN, 4'h4, "NOP_T3");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
   endtask

   task automatic test_add();
      exp_t e;
      IR = c_IR_ADD;
      push_fetch();
      push(M_RUN | M_GRB | M_ROUT | M_YIN, 4'h4, "ADD_T3");
      push(M_RUN | M_GRC | M_ROUT | M_ZLOWIN, 4'h4, "ADD_T4");
      push(M_RUN | M_ZLOWOUT | M_GRA | M_RIN, 4'h4, "ADD_T5");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
   endtask

   task automatic test_br();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         IR    = c_IR_BR;
         CONFF = (k == 0);
         push_fetch();
         push(M_RUN | M_GRA | M_ROUT | M_CONIN, 4'h4, "BR_T3");
         push(M_RUN | M_PCOUT | M_YIN, 4'h4, "BR_T4");
         push(M_RUN | M_CSIGN | M_ZLOWIN, 4'h4, "BR_T5");
         push(M_RUN | M_ZLOWOUT | ((k == 0) ? M_PCIN : 30'd0), 4'h4, (k == 0) ? "BR1_T6" : "BR0_T6");
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (obs !== e.sig || alu_op !== e.alu) begin
               n_fail++;
               $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
            end
            tick();
         end
      end
      CONFF = 1'b0;
   endtask

   task automatic test_neg();
      exp_t e;
      IR = c_IR_NEG;
      push_fetch();
      push(M_RUN | M_GRB | M_ROUT | M_ZLOWIN, 4'hC, "NEG_T3");
      push(M_RUN | M_ZLOWOUT | M_GRA | M_RIN, 4'h4, "NEG_T4");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
   endtask

   // ldi immediately followed by an undefined opcode (acts as nop)
   task automatic test_back_to_back();
      exp_t e;
      IR = c_IR_LDI;
      push_fetch();
      push(M_RUN | M_GRB | M_ROUT | M_YIN | M_BAOUT, 4'h4, "LDI_T3");
      push(M_RUN | M_CSIGN | M_ZLOWIN, 4'h4, "LDI_T4");
      push(M_RUN | M_ZLOWOUT | M_GRA | M_RIN, 4'h4, "LDI_T5");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
      IR = c_IR_UND;
      push_fetch();
      push(M_RUN, 4'h4, "UND_T3");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
   endtask

   // ld aborted by clear in T4, then a complete ld (with memory wait if enabled)
   task automatic test_ld();
      exp_t e;
      IR = c_IR_LD;
      push_fetch();
      push(M_RUN | M_GRB | M_BAOUT | M_YIN, 4'h4, "LD_T3");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
      push(M_RUN | M_CSIGN | M_ZLOWIN, 4'h4, "LD_T4");
      push(30'd0, 4'h4, "MID_CLR");
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e.sig || alu_op !== e.alu) begin
         n_fail++;
         $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
      end
      #2;
      clear = 1'b1;
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e.sig || alu_op !== e.alu) begin
         n_fail++;
         $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
      end
      clear = 1'b0;
      tick();
      push_fetch();
      push(M_RUN | M_GRB | M_BAOUT | M_YIN, 4'h4, "LD_T3");
      push(M_RUN | M_CSIGN | M_ZLOWIN, 4'h4, "LD_T4");
      push(M_RUN | M_ZLOWOUT | M_MARIN, 4'h4, "LD_T5");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
`ifdef CTRL_MEM_WAIT_EN
      mem_ready = 1'b0;
      for (int w = 0; w < 3; w++) begin
         push(M_RUN | M_READ | M_MDREAD | M_MDRIN, 4'h4, "LD_T6W");
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
      mem_ready = 1'b1;
`endif
      push(M_RUN | M_READ | M_MDREAD | M_MDRIN, 4'h4, "LD_T6");
      push(M_RUN | M_MDROUT | M_GRA | M_RIN, 4'h4, "LD_T7");
      push(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 4'h4, "LD_NEXT");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         if (sb_q.size() > 0) tick();
      end
   endtask

   // Stop held high through st: only the final state (T7) may act on it.
   task automatic test_stop();
      exp_t e;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      IR   = c_IR_ST;
      Stop = 1'b1;
      push_fetch();
      push(M_RUN | M_GRB | M_BAOUT | M_YIN, 4'h4, "ST_T3");
      push(M_RUN | M_CSIGN | M_ZLOWIN, 4'h4, "ST_T4");
      push(M_RUN | M_ZLOWOUT | M_MARIN, 4'h4, "ST_T5");
      push(M_RUN | M_GRA | M_ROUT | M_MDRIN, 4'h4, "ST_T6");
      push(M_RUN | M_WRITE, 4'h4, "ST_T7");
      push(30'd0, 4'h4, "ST_HALT");
      push(30'd0, 4'h4, "ST_HALT");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
      Stop = 1'b0;
   endtask

   task automatic test_mul_halt();
      exp_t e;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      IR = c_IR_MUL;
      push_fetch();
      push(M_RUN | M_GRA | M_ROUT | M_YIN, 4'h4, "MUL_T3");
      push(M_RUN | M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN, 4'hA, "MUL_T4");
      push(M_RUN | M_ZLOWOUT | M_LOIN, 4'h4, "MUL_T5");
      push(M_RUN | M_ZHIOUT | M_HIIN, 4'h4, "MUL_T6");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
      IR = c_IR_HALT;
      push_fetch();
      push(M_RUN, 4'h4, "HALT_T3");
      for (int h = 0; h < 20; h++) push(30'd0, 4'h4, "HALTED");
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (obs !== e.sig || alu_op !== e.alu) begin
            n_fail++;
            $display("FAIL %s: got sig=%h alu=%h, expected sig=%h alu=%h", e.tag, obs, alu_op, e.sig, e.alu);
         end
         tick();
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear    = 1'b1;
      IR       = c_IR_NOP;
      CONFF    = 1'b0;
      Stop     = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      test_reset();
      test_add();
      test_br();
      test_neg();
      test_back_to_back();
      test_ld();
      test_stop();
      test_mul_halt();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Hardwired Moore sequencer for the Mini SRC CPU that drives every control input of the datapath.
- It fetches an instruction, decodes `IR[31:27]`, and steps through execute states T3–T7.
- It asserts register-select, bus-source, register-load, ALU, memory and I/O strobes.
- It sits beside the datapath and reads back only `IR` and `CONFF`.

## Interface
Parameters:
- `ALU_ADD`, 4'h4: ALU op code for add. The other op codes are fixed in Operation.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `IR`  in  32  instruction register contents; opcode is `IR[31:27]`.
- `CONFF`  in  1  branch-condition flip-flop from the datapath.
- `Stop`  in  1  halt request, honoured at the next instruction boundary.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Csignout`  out  1 each  select/encode controls.
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `MD_read`, `IRin`, `Yin`  out  1 each.
- `Zlowin`, `Zhighin`, `Zlowout`, `Zhighout`, `HIin`, `LOin`, `HIout`, `LOout`  out  1 each.
- `Read`, `Write`, `InPortout`, `Out_Portin`, `CONin`  out  1 each.
- `alu_op`  out  4  ALU operation select.
- `Run`  out  1  high while the CPU is executing.

## Operation
**States:** RESET, T0–T7, HALT. All outputs are a pure decode of the state register plus the `IR` opcode. Outputs not listed for a state are 0, and `alu_op` defaults to `ALU_ADD`.

**Fetch:**
- T0: `PCout`, `MARin`, `IncPC`, `Zlowin`.
- T1: `Zlowout`, `PCin`, `Read`, `MD_read`, `MDRin`.
- T2: `MDRout`, `IRin`.

**Opcodes and `alu_op` codes:**
- ld 0, ldi 1, st 2.
- add 3 (4'h4), sub 4 (4'h5), and 5 (4'h0), or 6 (4'h1), shr 7 (4'h6), shl 8 (4'h7), ror 9 (4'h8), rol 10 (4'h9).
- addi 11 (4'h4), andi 12 (4'h0), ori 13 (4'h1).
- mul 14 (4'hA), div 15 (4'hB), neg 16 (4'hC), not 17 (4'hD).
- br 18, jr 19, in 21, out 22, mfhi 23, mflo 24, nop 25, halt 26.
- Undefined opcodes (including 20) behave as nop.

**Execute sequences:**
- Register ALU (add–rol):
  - T3 `Grb` `Rout` `Yin`
  - T4 `Grc` `Rout` `alu_op` `Zlowin`
  - T5 `Zlowout` `Gra` `Rin`
- Immediate (addi/andi/ori/ldi):
  - T3 `Grb` `Rout` `Yin`; ldi also asserts `BAout`
  - T4 `Csignout` `alu_op` `Zlowin`
  - T5 `Zlowout` `Gra` `Rin`
- ld/st share an address phase:
  - T3 `Grb` `BAout` `Yin`
  - T4 `Csignout` ADD `Zlowin`
  - T5 `Zlowout` `MARin`
- ld then continues:
  - T6 `Read` `MD_read` `MDRin`
  - T7 `MDRout` `Gra` `Rin`
- st then continues:
  - T6 `Gra` `Rout` `MDRin`
  - T7 `Write`
- mul/div:
  - T3 `Gra` `Rout` `Yin`
  - T4 `Grb` `Rout` `alu_op` `Zlowin` `Zhighin`
  - T5 `Zlowout` `LOin`
  - T6 `Zhighout` `HIin`
- neg/not:
  - T3 `Grb` `Rout` `alu_op` `Zlowin`
  - T4 `Zlowout` `Gra` `Rin`
- br:
  - T3 `Gra` `Rout` `CONin`
  - T4 `PCout` `Yin`
  - T5 `Csignout` ADD `Zlowin`
  - T6 `Zlowout` `PCin`, with `PCin` gated by `CONFF`
- Single-state instructions:
  - jr: T3 `Gra` `Rout` `PCin`
  - in: T3 `InPortout` `Gra` `Rin`
  - out: T3 `Gra` `Rout` `Out_Portin`
  - mfhi: T3 `HIout` `Gra` `Rin`
  - mflo: T3 `LOout` `Gra` `Rin`
  - nop: T3, no strobes
- halt: T3 → HALT.

**Instruction end:** after the last listed state, the next state is T0. If `Stop`=1 in that last state, the next state is HALT instead.

**HALT:** `Run`=0 and all strobes are 0. HALT is left only by `clear`.

## Timing
- `clear`=1 forces RESET immediately, including mid-instruction. All outputs are 0 during reset, `Run`=0, and `alu_op`=`ALU_ADD`.
- The first rising edge with `clear`=0 moves RESET → T0 and sets `Run`=1.
- Each state lasts exactly one cycle.
- Per-instruction latency:
  - jr/in/out/mfhi/mflo/nop: 4 cycles.
  - neg/not: 5 cycles.
  - ALU, immediate: 6 cycles.
  - br, mul, div: 7 cycles.
  - ld, st: 8 cycles.
- `IR` is loaded at the end of T2, so decode uses `IR` from T3 onward.
- `CONFF` is latched at the end of T3 and sampled in T6.
- `Stop` is sampled only in an instruction's final state.

## Configuration
`CTRL_MEM_WAIT_EN`:
- **Defined:** adds input `mem_ready` (1 bit). Any state asserting `Read` or `Write` (T1; ld T6; st T7) holds, with identical outputs, until `mem_ready`=1 at a rising edge. `Stop` is still evaluated when the held state exits.
- **Undefined:** the `mem_ready` port is absent and those states last one cycle.

## Test plan
- **Reset and fetch:** release `clear` with `IR`=nop (0xC8000000). Expect RESET→T0→T1→T2→T3→T0, `Run`=1, T0 asserting `PCout`/`MARin`/`IncPC`/`Zlowin`, and a 4-cycle period.
- **add:** `IR`=0x18918000 (add r1,r2,r3). Expect T3 `Grb`+`Yin`, T4 `Grc`+`alu_op`=4'h4+`Zlowin`, T5 `Zlowout`+`Gra`+`Rin`, then T0.
- **br:** `IR`=0x90000014. With `CONFF`=1, T6 asserts `PCin`; with `CONFF`=0, T6 has `Zlowout` but no `PCin`. Both cases take 7 cycles.
- **ld with wait (`CTRL_MEM_WAIT_EN`):** hold `mem_ready`=0 for 3 cycles in T6. Expect `Read`/`MD_read`/`MDRin` held for 4 cycles, then T7 `MDRout`+`Gra`+`Rin`.
- **mul, then halt:** mul asserts `LOin` in T5 and `HIin` in T6 with `alu_op`=4'hA. A following halt instruction reaches HALT with `Run`=0 and holds there for 20 cycles.
- **Stop and mid-instruction reset:** `Stop`=1 during st T7 goes to HALT. `clear` asserted mid-T4 of ld immediately zeroes all outputs.
